uart_tx_arbiter: RTL and testbench

- Shares one async_transmitter (8N2 serial TX) among NREQ byte-stream requesters.
- Per-requester valid/ready byte handshake; round-robin arbitration.
- Packet lock: once a requester wins, it keeps the transmitter until its byte flagged last has gone out, so packets never interleave on TxD.
- Sits between firmware/DMA byte sources and the transmitter's TxD_start/TxD_data/TxD_busy pins.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N2 async transmitter among NREQ byte streams.
// The winner holds a packet lock until its last byte is sent or it stalls too long.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [NREQ-1:0]   grant,
  output logic              lock_timeout
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t        state, stateNext;
  logic          lock;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;
  logic          holdLast;
  logic [CW-1:0] toCnt;
  logic          handshake;
  logic          toRun;
  logic          expire;
  logic          charDone;
  logic [7:0]    reqByte [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      reqByte[i] = req_data[8*i +: 8];
    end
  end

  // Locked: only the owner may win. Unlocked: first valid after ptr, wrapping.
  always_comb begin
    win   = owner;
    found = 1'b0;
    idx   = '0;
    if (lock) begin
      found = req_valid[owner];
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = IW'((32'(ptr) + k) % NREQ);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (handshake) stateNext = START;
      START:   stateNext = WAIT_HI;
      WAIT_HI: if (tx_busy) stateNext = WAIT_LO;
      WAIT_LO: if (!tx_busy) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    handshake = (state == IDLE) && found && !tx_busy;
    if (handshake) req_ready[win] = 1'b1;
    toRun    = (state == IDLE) && lock && !req_valid[owner];
    expire   = toRun && (toCnt == CW'(LOCK_TIMEOUT - 1));
    charDone = (state == WAIT_LO) && !tx_busy;
  end

  // tx_data doubles as the holding register for the accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock         <= 1'b0;
      ptr          <= IW'(NREQ - 1);
      owner        <= '0;
      holdLast     <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant        <= '0;
      lock_timeout <= 1'b0;
      toCnt        <= '0;
    end else begin
      tx_start     <= handshake;
      lock_timeout <= expire;
      if (handshake) begin
        tx_data  <= reqByte[win];
        holdLast <= req_last[win];
        owner    <= win;
        grant    <= NREQ'(1) << win;
      end
      if (charDone) begin
        if (holdLast) begin
          lock  <= 1'b0;
          grant <= '0;
          ptr   <= owner;
        end else begin
          lock <= 1'b1;
        end
      end
      if (expire) begin
        lock  <= 1'b0;
        grant <= '0;
        ptr   <= owner;
      end
      if (handshake || !toRun || expire) toCnt <= '0;
      else                               toCnt <= toCnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a behavioural transmitter busy
// model and a packet-level round-robin reference for the expected TX order.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int LT   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [NREQ-1:0]   grant;
  logic              lock_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant),
    .lock_timeout(lock_timeout)
  );

  logic [8:0] qMem [NREQ][64];
  int         qHead [NREQ];
  int         qTail [NREQ];
  logic [7:0] expByte [256];
  int         expOwn [256];
  int         expCnt, hsIdx, obsIdx;
  int         cyc, hsCyc, fallCyc, expToCyc, mPtr, busyCnt;
  bit         forceBusy, prevBusy;
  int         passCnt, totalCnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (qHead[i] < qTail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qMem[i][qHead[i]][7:0];
        req_last[i]        = qMem[i][qHead[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input bit last);
    qMem[r][qTail[r]] = {last, b};
    qTail[r]++;
  endtask

  task automatic newTest();
    expCnt = 0; hsIdx = 0; obsIdx = 0;
    for (int i = 0; i < NREQ; i++) begin qHead[i] = 0; qTail[i] = 0; end
  endtask

  task automatic expect1(input logic [7:0] b, input int own);
    expByte[expCnt] = b;
    expOwn[expCnt]  = own;
    expCnt++;
  endtask

  // Whole packets leave in round-robin order starting after the last owner.
  task automatic modelOrder();
    int h [NREQ];
    int sel, i;
    logic [8:0] e;
    for (int r = 0; r < NREQ; r++) h[r] = qHead[r];
    for (int guard = 0; guard < 64; guard++) begin
      sel = -1;
      for (int k = 1; k <= NREQ; k++) begin
        i = (mPtr + k) % NREQ;
        if (sel < 0 && h[i] < qTail[i]) sel = i;
      end
      if (sel < 0) break;
      do begin
        e = qMem[sel][h[sel]];
        h[sel]++;
        expect1(e[7:0], sel);
      end while (!e[8] && h[sel] < qTail[sel]);
      mPtr = sel;
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] hs;
    bit started;
    @(negedge clk);
    hs = req_valid & req_ready;
    chk("ready_busy", req_ready & {NREQ{tx_busy}}, 0);
    chk("ready_valid", req_ready & ~req_valid, 0);
    if (hsIdx < expCnt) chk("ready_owner", req_ready & ~(4'b1 << expOwn[hsIdx]), 0);
    else chk("ready_idle", req_ready, 0);
    if (hs != 0) begin hsCyc = cyc; hsIdx++; end
    if (tx_start) begin
      chk("start_latency", cyc, hsCyc + 1);
      if (obsIdx < expCnt) begin
        chk("tx_data", tx_data, expByte[obsIdx]);
        chk("grant_owner", grant, 1 << expOwn[obsIdx]);
      end else chk("extra_start", tx_start, 0);
      obsIdx++;
    end
    chk("start_vs_busy", tx_start & tx_busy, 0);
    chk("lock_timeout", lock_timeout, cyc == expToCyc);
    if (cyc == expToCyc) chk("timeout_grant", grant, 0);
    if (prevBusy && !tx_busy) fallCyc = cyc;
    prevBusy = tx_busy;
    started  = tx_start;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (hs[i]) qHead[i]++;
    drive();
    if (started) busyCnt = $urandom_range(10, 4);
    else if (busyCnt > 0) busyCnt--;
    tx_busy = forceBusy || (busyCnt != 0);
  endtask

  task automatic drain(input string tag);
    int budget;
    bit empty;
    budget = 0;
    forever begin
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (qHead[i] < qTail[i]) empty = 1'b0;
      if ((empty && obsIdx == expCnt && hsIdx == expCnt && busyCnt == 0) || budget >= 3000) break;
      cycle();
      budget++;
    end
    repeat (3) cycle();
    chk({tag, "_drain"}, budget < 3000, 1);
    chk({tag, "_count"}, obsIdx, expCnt);
    chk({tag, "_idle_grant"}, grant, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int relCyc, n;
    passCnt = 0; totalCnt = 0; cyc = 0; hsCyc = -10; fallCyc = -1; expToCyc = -1;
    busyCnt = 0; forceBusy = 0; prevBusy = 0; mPtr = NREQ - 1;
    rst = 1'b1; tx_busy = 1'b0;
    newTest();
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_lock_timeout", lock_timeout, 0);
    chk("rst_ready", req_ready, 0);
    repeat (4) cycle();

    // single-byte packet
    newTest(); push(2, 8'h5A, 1); modelOrder(); drive();
    chk("single_exp", expByte[0], 8'h5A);
    drain("single");

    // round-robin with one-byte packets
    newTest();
    for (int r = 0; r < NREQ; r++) begin push(r, 8'h10 + 8'(r), 1); push(r, 8'h10 + 8'(r), 1); end
    modelOrder(); drive();
    drain("rr");

    // packet lock
    newTest();
    push(0, 8'hA0, 0); push(0, 8'hA1, 0); push(0, 8'hA2, 1); push(1, 8'hB0, 1);
    modelOrder(); drive();
    drain("lock");

    // lock timeout: owner stalls mid-packet, requester 1 waits
    newTest();
    push(3, 8'h33, 0); push(1, 8'h44, 1);
    expect1(8'h33, 3); expect1(8'h44, 1);
    drive(); fallCyc = -1;
    n = 0;
    while (!(fallCyc >= 0 && obsIdx >= 1) && n < 200) begin cycle(); n++; end
    chk("to_char_done", n < 200, 1);
    expToCyc = fallCyc + LT + 1;
    drain("timeout");
    chk("to_accept_cycle", hsCyc, expToCyc);
    expToCyc = -1; mPtr = 1;

    // reset while the first byte of a 3-byte packet is still on the line
    newTest();
    push(0, 8'hC0, 0); push(0, 8'hC1, 0); push(0, 8'hC2, 1);
    expect1(8'hC0, 0);
    drive();
    n = 0;
    while (obsIdx < 1 && n < 100) begin cycle(); n++; end
    chk("rst_mid_start", obsIdx, 1);
    cycle();
    newTest(); mPtr = NREQ - 1;
    push(1, 8'hE0, 1); push(0, 8'hD0, 1);
    modelOrder();
    rst = 1'b1; drive();
    cycle();
    rst = 1'b0;
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_start0", tx_start, 0);
    chk("rst_mid_busy", tx_busy, 1);
    chk("rst_mid_order", expOwn[0], 0);
    drain("rst_mid");

    // external back-pressure
    newTest(); push(1, 8'h77, 1); modelOrder(); drive();
    forceBusy = 1; tx_busy = 1;
    repeat (20) cycle();
    chk("bp_no_hs", hsIdx, 0);
    forceBusy = 0; tx_busy = (busyCnt != 0); relCyc = cyc;
    drain("bp");
    chk("bp_after_release", hsCyc >= relCyc, 1);

    // randomized packet mixes
    for (int t = 0; t < 4; t++) begin
      newTest();
      for (int r = 0; r < NREQ; r++) begin
        for (int p = 0; p < int'($urandom_range(2, 0)); p++) begin
          n = $urandom_range(4, 1);
          for (int b = 0; b < n; b++) push(r, 8'($urandom), b == n - 1);
        end
      end
      modelOrder(); drive();
      drain("rand");
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
